// File: rtl/load_ext.sv
// load_ext: load-data lane extraction and sign/zero extension for the MIPS
// writeback path. Results leave through a valid/ready stage backed by a
// one-entry skid register, so one load per cycle survives backpressure.
module load_ext #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 5,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int OFF_W      = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [2:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_misalign,
  output logic              out_illegal,
  output logic [15:0]       misalign_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              mis;
    logic              ill;
  } ent_t;

  ent_t              in_ent, out_q, skid_q;
  logic              out_v, skid_v;
  logic              accept, deliver;

  logic [3:0]        nbytes;
  logic [3:0]        off_ext;
  logic              ill, mis, sign;
  int                lsb, nbits;
  logic [DATA_W-1:0] shifted, mask, ext;

  // Decode access size, check alignment/legality and extract the lane.
  // The lane MSB is found as the top set bit of the lane mask, which keeps
  // the sign pick free of variable bit selects.
  always_comb begin
    nbytes  = 4'd1 << in_mode[2:1];
    off_ext = 4'(in_off);
    ill     = (in_mode == 3'b111) || (in_mode == 3'b110 && DATA_W == 32);
    mis     = !ill && (|(off_ext & (nbytes - 4'd1)));
    nbits   = 8 * int'(nbytes);
    if (nbits > DATA_W) nbits = DATA_W;
    if (BIG_ENDIAN) lsb = DATA_W - 8 * (int'(off_ext) + int'(nbytes));
    else            lsb = 8 * int'(off_ext);
    // Errored beats return zero, so their lane position is irrelevant.
    if (ill || mis || lsb < 0) lsb = 0;
    shifted = in_data >> lsb;
    mask    = (nbits >= DATA_W) ? {DATA_W{1'b1}} : ~({DATA_W{1'b1}} << nbits);
    sign    = !in_mode[0] && (|(shifted & mask & ~(mask >> 1)));
    ext     = (shifted & mask) | (sign ? ~mask : {DATA_W{1'b0}});
    in_ent.data = (ill || mis) ? {DATA_W{1'b0}} : ext;
    in_ent.tag  = in_tag;
    in_ent.mis  = mis;
    in_ent.ill  = ill;
  end

  // in_ready comes only from registered state and flush.
  assign in_ready = !skid_v && !flush;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_v && out_ready;

  // Output register plus skid register; skid drains into output on delivery.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (deliver) begin
      if (skid_v) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end else if (accept) begin
        out_q  <= in_ent;
      end else begin
        out_v  <= 1'b0;
      end
    end else if (accept) begin
      if (!out_v) begin
        out_q <= in_ent;
        out_v <= 1'b1;
      end else begin
        skid_q <= in_ent;
        skid_v <= 1'b1;
      end
    end
  end

  // Saturating count of misaligned beats actually handed to the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n)
      misalign_cnt <= '0;
    else if (deliver && out_q.mis && misalign_cnt != 16'hFFFF)
      misalign_cnt <= misalign_cnt + 16'd1;
  end

  assign out_valid    = out_v;
  assign out_data     = out_q.data;
  assign out_tag      = out_q.tag;
  assign out_misalign = out_q.mis;
  assign out_illegal  = out_q.ill;

endmodule

// File: tb/tb_load_ext.sv
// tb_load_ext: directed and random checks of load_ext in two configurations,
// DATA_W=32 little-endian (index 0) and DATA_W=64 big-endian (index 1),
// against a byte-level reference model and a per-instance scoreboard.
module tb_load_ext;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  tag;
    logic        mis;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv[2], ordy[2], fl[2];
  logic [63:0] idata[2];
  logic [2:0]  off[2], mode[2];
  logic [4:0]  itag[2];

  logic        ir[2], ov[2], mis[2], ill[2];
  logic [63:0] od[2];
  logic [4:0]  otag[2];
  logic [15:0] cnt[2];
  logic [31:0] od0;
  logic [63:0] od1;

  int   n_chk = 0, n_fail = 0;
  exp_t sb[2][$];
  int   mcnt[2];

  load_ext #(.DATA_W(32), .TAG_W(5), .BIG_ENDIAN(1'b0)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0][31:0]),
    .in_off(off[0][1:0]), .in_mode(mode[0]), .in_tag(itag[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .out_tag(otag[0]),
    .out_misalign(mis[0]), .out_illegal(ill[0]), .misalign_cnt(cnt[0])
  );

  load_ext #(.DATA_W(64), .TAG_W(5), .BIG_ENDIAN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1]),
    .in_off(off[1]), .in_mode(mode[1]), .in_tag(itag[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .out_tag(otag[1]),
    .out_misalign(mis[1]), .out_illegal(ill[1]), .misalign_cnt(cnt[1])
  );

  assign od[0] = {32'd0, od0};
  assign od[1] = od1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: gather the S addressed bytes in memory order, assemble them
  // in the configured byte order, then extend arithmetically.
  function automatic exp_t model(input int k, input logic [63:0] d, input int o,
                                 input logic [2:0] m, input logic [4:0] t);
    exp_t        e;
    int          dw, s;
    logic [63:0] v;
    logic [7:0]  b;
    dw = (k == 0) ? 32 : 64;
    s  = 1 << m[2:1];
    e.tag = t;
    e.ill = (m == 3'd7) || (m == 3'd6 && dw == 32);
    e.mis = !e.ill && (o % s != 0);
    v = 64'd0;
    if (!e.ill && !e.mis) begin
      for (int i = 0; i < s; i++) begin
        if (k == 1) begin
          b = d[(dw - 1 - 8 * (o + i)) -: 8];
          v = (v << 8) | 64'(b);
        end else begin
          b = d[8 * (o + i) +: 8];
          v = v | (64'(b) << (8 * i));
        end
      end
      if (!m[0] && s < 8 && v[8 * s - 1]) v = v | (~64'd0 << (8 * s));
      if (dw == 32) v[63:32] = 32'd0;
    end
    e.d = v;
    return e;
  endfunction

  // Scoreboard: occupancy, ordering, payload and counter checked every cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int   pre;
      exp_t e;
      if (!rst_n) begin
        sb[k].delete();
        mcnt[k] = 0;
      end else begin
        pre = sb[k].size();
        chk($sformatf("d%0d.in_ready", k), 64'(ir[k]), 64'(pre < 2 && !fl[k]));
        chk($sformatf("d%0d.out_valid", k), 64'(ov[k]), 64'(pre > 0));
        chk($sformatf("d%0d.misalign_cnt", k), 64'(cnt[k]), 64'(mcnt[k]));
        if (ov[k] && ordy[k] && pre > 0) begin
          e = sb[k].pop_front();
          chk($sformatf("d%0d.data", k), od[k], e.d);
          chk($sformatf("d%0d.tag", k), 64'(otag[k]), 64'(e.tag));
          chk($sformatf("d%0d.misalign", k), 64'(mis[k]), 64'(e.mis));
          chk($sformatf("d%0d.illegal", k), 64'(ill[k]), 64'(e.ill));
          if (e.mis && mcnt[k] < 16'hFFFF) mcnt[k]++;
        end
        if (iv[k] && pre < 2 && !fl[k])
          sb[k].push_back(model(k, idata[k], int'(off[k]), mode[k], itag[k]));
        if (fl[k]) sb[k].delete();
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input int k, input logic v, input logic [63:0] d,
                        input logic [2:0] o, input logic [2:0] m, input logic [4:0] t);
    iv[k] = v; idata[k] = d; off[k] = o; mode[k] = m; itag[k] = t;
  endtask

  // One beat with out_ready high; result checked one cycle after accept.
  task automatic beat(input int k, input logic [63:0] d, input logic [2:0] o,
                      input logic [2:0] m, input logic [4:0] t,
                      input logic [63:0] xd, input logic xm, input logic xi);
    cyc();
    set_in(k, 1'b1, d, o, m, t);
    ordy[k] = 1'b1;
    cyc();
    iv[k] = 1'b0;
    @(negedge clk);
    chk("beat.valid", 64'(ov[k]), 64'd1);
    chk("beat.data", od[k], xd);
    chk("beat.tag", 64'(otag[k]), 64'(t));
    chk("beat.misalign", 64'(mis[k]), 64'(xm));
    chk("beat.illegal", 64'(ill[k]), 64'(xi));
  endtask

  task automatic check_reset_state();
    for (int k = 0; k < 2; k++) begin
      chk("rst.out_valid", 64'(ov[k]), 64'd0);
      chk("rst.out_data", od[k], 64'd0);
      chk("rst.out_tag", 64'(otag[k]), 64'd0);
      chk("rst.flags", 64'({mis[k], ill[k]}), 64'd0);
      chk("rst.in_ready", 64'(ir[k]), 64'd1);
      chk("rst.cnt", 64'(cnt[k]), 64'd0);
    end
  endtask

  localparam logic [63:0] D32 = 64'h0000_0000_8765_43F0;
  localparam logic [63:0] D64 = 64'h0123_4567_89AB_CDEF;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_in(k, 1'b0, 64'd0, 3'd0, 3'd0, 5'd0);
      ordy[k] = 1'b0;
      fl[k]   = 1'b0;
    end
    repeat (3) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state();

    // 32-bit little-endian extraction
    beat(0, D32, 3'd0, 3'd0, 5'd1, 64'hFFFF_FFF0, 1'b0, 1'b0);
    beat(0, D32, 3'd1, 3'd1, 5'd2, 64'h0000_0043, 1'b0, 1'b0);
    beat(0, D32, 3'd2, 3'd2, 5'd3, 64'hFFFF_8765, 1'b0, 1'b0);
    beat(0, D32, 3'd2, 3'd3, 5'd4, 64'h0000_8765, 1'b0, 1'b0);
    beat(0, D32, 3'd0, 3'd4, 5'd5, 64'h8765_43F0, 1'b0, 1'b0);
    beat(0, D32, 3'd0, 3'd5, 5'd6, 64'h8765_43F0, 1'b0, 1'b0);
    // Errors: misaligned lh, reserved mode, ld on 32-bit
    beat(0, D32, 3'd1, 3'd2, 5'd7, 64'd0, 1'b1, 1'b0);
    cyc(); @(negedge clk);
    chk("cnt.after_misalign", 64'(cnt[0]), 64'd1);
    beat(0, D32, 3'd1, 3'd7, 5'd8, 64'd0, 1'b0, 1'b1);
    beat(0, D32, 3'd0, 3'd6, 5'd9, 64'd0, 1'b0, 1'b1);
    cyc(); @(negedge clk);
    chk("cnt.after_illegal", 64'(cnt[0]), 64'd1);

    // 64-bit big-endian extraction
    beat(1, D64, 3'd0, 3'd0, 5'd1, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    beat(1, D64, 3'd6, 3'd2, 5'd2, 64'hFFFF_FFFF_FFFF_CDEF, 1'b0, 1'b0);
    beat(1, D64, 3'd4, 3'd4, 5'd3, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1'b0);
    beat(1, D64, 3'd0, 3'd6, 5'd4, D64, 1'b0, 1'b0);
    beat(1, D64, 3'd4, 3'd6, 5'd5, 64'd0, 1'b1, 1'b0);
    cyc(); cyc();

    // Backpressure: three beats into a stalled output
    ordy[0] = 1'b0; set_in(0, 1'b1, D32, 3'd0, 3'd1, 5'd1);
    @(negedge clk); chk("bp.c1.in_ready", 64'(ir[0]), 64'd1);
    cyc(); itag[0] = 5'd2;
    @(negedge clk); chk("bp.c2.in_ready", 64'(ir[0]), 64'd1);
    cyc(); itag[0] = 5'd3;
    @(negedge clk); chk("bp.c3.in_ready", 64'(ir[0]), 64'd0);
    chk("bp.c3.tag", 64'(otag[0]), 64'd1);
    cyc(); ordy[0] = 1'b1;
    @(negedge clk); chk("bp.c4.tag", 64'(otag[0]), 64'd1);
    chk("bp.c4.in_ready", 64'(ir[0]), 64'd0);
    cyc();
    @(negedge clk); chk("bp.c5.tag", 64'(otag[0]), 64'd2);
    chk("bp.c5.in_ready", 64'(ir[0]), 64'd1);
    cyc(); iv[0] = 1'b0;
    @(negedge clk); chk("bp.c6.tag", 64'(otag[0]), 64'd3);
    chk("bp.c6.valid", 64'(ov[0]), 64'd1);
    cyc();
    @(negedge clk); chk("bp.c7.valid", 64'(ov[0]), 64'd0);

    // Flush with both entries full and a beat presented
    cyc(); ordy[0] = 1'b0; set_in(0, 1'b1, D32, 3'd0, 3'd0, 5'd4);
    cyc(); itag[0] = 5'd5;
    cyc(); itag[0] = 5'd6; fl[0] = 1'b1;
    @(negedge clk); chk("fl.in_ready", 64'(ir[0]), 64'd0);
    cyc(); fl[0] = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk); chk("fl.valid", 64'(ov[0]), 64'd0);
    chk("fl.in_ready_after", 64'(ir[0]), 64'd1);
    cyc(); @(negedge clk); chk("fl.no_ghost", 64'(ov[0]), 64'd0);

    // Reset mid-stream with both entries full
    cyc(); ordy[0] = 1'b0; set_in(0, 1'b1, D32, 3'd1, 3'd2, 5'd7);
    cyc(); itag[0] = 5'd8;
    cyc(); iv[0] = 1'b0; rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    check_reset_state();
    beat(0, D32, 3'd1, 3'd1, 5'd9, 64'h0000_0043, 1'b0, 1'b0);

    // Random traffic against the scoreboard
    for (int n = 0; n < 4000; n++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        logic [2:0] o;
        o = (k == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) o = 3'd0;
        set_in(k, $urandom_range(0, 3) != 0, {$urandom, $urandom}, o,
               3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        ordy[k] = $urandom_range(0, 2) != 0;
        fl[k]   = $urandom_range(0, 39) == 0;
      end
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (4) cyc();
    @(negedge clk);
    chk("drain.d0", 64'(ov[0]), 64'd0);
    chk("drain.d1", 64'(ov[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_ext.md
# load_ext

Registered, parametrised load-data extension unit between the data-memory read port and writeback in the MIPS pipeline. It selects a byte, halfword, word or doubleword lane from a memory read word by address offset. It then sign- or zero-extends that lane to the full datapath width and flags misaligned or illegal accesses. Results are delivered through a valid/ready output stage with a one-entry skid buffer, so the unit sustains one load per cycle under backpressure.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64
- TAG_W, 5, width of the destination-register tag carried alongside data
- BIG_ENDIAN, 0, lane numbering; 0 = byte 0 at bits [7:0], 1 = byte 0 at bits [DATA_W-1:DATA_W-8]
- OFF_W, $clog2(DATA_W/8), offset width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  input beat present
- in_ready  out  1  unit can accept a beat this cycle
- in_data  in  DATA_W  raw memory read word
- in_off  in  OFF_W  byte offset of the access within in_data
- in_mode  in  3  000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw, 101 lwu, 110 ld, 111 reserved
- in_tag  in  TAG_W  destination tag, passed through unchanged
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts the output beat
- out_data  out  DATA_W  extended result
- out_tag  out  TAG_W  tag of the output beat
- out_misalign  out  1  access not naturally aligned
- out_illegal  out  1  reserved mode, or ld with DATA_W=32
- misalign_cnt  out  16  saturating count of misaligned beats delivered

## Operation
- Access size S is 1, 2, 4 or 8 bytes by mode. Unsigned modes zero-extend. lb, lh and lw sign-extend from the MSB of the selected lane. ld is full width.
- Lane start bit:
  - BIG_ENDIAN=0: 8*in_off
  - BIG_ENDIAN=1: DATA_W - 8*(in_off+S)
- lw/lwu with DATA_W=32 are identical and return in_data unmodified.
- Misaligned (in_off mod S != 0): out_data=0, out_misalign=1, out_illegal=0.
- Illegal (mode 111, or mode 110 with DATA_W=32): out_data=0, out_illegal=1, out_misalign=0. Illegal takes priority over misaligned.
- A beat is accepted when in_valid && in_ready. A beat is delivered when out_valid && out_ready.
- Storage is two entries: an output register and a skid register. in_ready = !skid_valid && !flush.
  - If the output register is empty, or is being delivered in the same cycle, the accepted beat loads the output register.
  - Otherwise the accepted beat loads the skid register.
  - On delivery with the skid register full, the skid entry moves to the output register and the skid register empties.
- Beat order is preserved, and no beat is dropped or duplicated except by flush.
- misalign_cnt increments on each delivered beat with out_misalign=1 and saturates at 0xFFFF. Flush does not clear it.

## Timing
- Latency: 1 cycle from accept to out_valid when the output register is empty. Throughput: 1 beat/cycle while out_ready=1.
- Reset (rst_n low at a clock edge) clears everything, including any in-flight beat:
  - out_valid=0, out_data=0, out_tag=0, out_misalign=0, out_illegal=0
  - skid register empty, misalign_cnt=0
  - in_ready=1 from the first cycle with rst_n high.
- Flush high at an edge empties both entries: out_valid=0 next cycle.
  - in_ready=0 during the flush cycle; an input beat presented in that cycle is not accepted.
  - rst_n low overrides flush.
- out_data, out_tag and flags hold stable while out_valid=1 && out_ready=0.
- in_ready depends only on registered state and flush, with no combinational path from out_ready.
- out_ready may drop at any cycle with no protocol violation.

## Test plan
- Extraction, DATA_W=32, in_data=0x876543F0:
  - lb off=0 -> 0xFFFFFFF0
  - lbu off=1 -> 0x00000043
  - lh off=2 -> 0xFFFF8765
  - lhu off=2 -> 0x00008765
  - lw off=0 -> 0x876543F0
  - each one cycle after accept.
- Errors: lh off=1 -> out_data=0, out_misalign=1, misalign_cnt 0->1. Mode 111 or ld at DATA_W=32 -> out_illegal=1, out_data=0, count unchanged.
- Backpressure: out_ready=0 with 3 consecutive in_valid beats (tags 1,2,3).
  - Beats 1 and 2 are accepted; in_ready=0 after beat 2.
  - Raise out_ready: delivered order is 1,2,3, with no gap once streaming.
- Flush: with both entries full, assert flush for one cycle with in_valid=1.
  - Next cycle out_valid=0 and in_ready=1.
  - The beat presented during flush never appears.
- Reset mid-stream: rst_n low for one edge with both entries full -> all outputs zero and misalign_cnt=0. First accepted beat afterwards appears after 1 cycle.
- DATA_W=64, BIG_ENDIAN=1, in_data=0x0123456789ABCDEF:
  - lb off=0 -> 0x0000000000000001
  - lh off=6 -> 0xFFFFFFFFFFFFCDEF
  - lw off=4 -> 0xFFFFFFFF89ABCDEF
  - ld -> in_data unchanged.
